// File: rtl/mm2s_byte_serializer.sv
// Serializes 64-bit datamover read-back beats into a byte stream for an Ethernet MAC.
// Frames end on a byte-count limit or on the last kept byte of a beat flagged tlast.
module mm2s_byte_serializer #(
    parameter int unsigned FRAME_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [15:0] frame_count,
    output logic        null_beat_err
);

    localparam logic [0:0]  ST_EMPTY = 1'b0;
    localparam logic [0:0]  ST_HOLD  = 1'b1;
    localparam logic [15:0] LAST_IDX = 16'(FRAME_BYTES - 1);

    function automatic logic [7:0] lowest_bit(input logic [7:0] m);
        return m & (~m + 8'd1);
    endfunction

    function automatic logic single_bit(input logic [7:0] m);
        return (m != 8'd0) && ((m & (m - 8'd1)) == 8'd0);
    endfunction

    // Lowest-indexed pending byte wins, matching the little-endian emit order.
    function automatic logic [7:0] pick_byte(input logic [63:0] d, input logic [7:0] m);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 7; i >= 0; i--) begin
            r = m[i] ? d[8*i +: 8] : r;
        end
        return r;
    endfunction

    logic [0:0]  state_q, state_d;
    logic [63:0] data_q, data_d;
    logic [7:0]  mask_q, mask_d;
    logic        hlast_q, hlast_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] frame_q, frame_d;
    logic        err_q, err_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tlast_q, tlast_d;

    logic        hs_s;
    logic        tready_s;
    logic        accept_s;
    logic [7:0]  mask_after_s;

    // Handshake decode and input-side ready; refill is allowed on the final byte's handshake.
    always_comb begin
        hs_s         = (state_q == ST_HOLD) && m_axis_tready;
        if (hs_s) begin
            mask_after_s = mask_q & ~lowest_bit(mask_q);
        end else begin
            mask_after_s = mask_q;
        end
        tready_s = !reset && ((mask_q == 8'd0) || (single_bit(mask_q) && hs_s));
        accept_s = s_axis_tvalid && tready_s;
    end

    // Next-state for the held beat, counters and the registered output byte.
    always_comb begin
        data_d  = data_q;
        mask_d  = mask_after_s;
        hlast_d = hlast_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        err_d   = err_q;
        state_d = state_q;

        if (accept_s) begin
            data_d  = s_axis_tdata;
            mask_d  = s_axis_tkeep;
            // An empty beat's tlast is dropped so it can never close a frame.
            hlast_d = (s_axis_tkeep != 8'd0) && s_axis_tlast;
            err_d   = err_q | (s_axis_tkeep == 8'd0);
        end else if (mask_after_s == 8'd0) begin
            hlast_d = 1'b0;
        end else begin
            hlast_d = hlast_q;
        end

        if (hs_s) begin
            if (tlast_q) begin
                cnt_d   = 16'd0;
                frame_d = frame_q + 16'd1;
            end else begin
                cnt_d   = cnt_q + 16'd1;
                frame_d = frame_q;
            end
        end else begin
            cnt_d   = cnt_q;
            frame_d = frame_q;
        end

        case (state_q)
            ST_EMPTY: state_d = (mask_d != 8'd0) ? ST_HOLD : ST_EMPTY;
            ST_HOLD:  state_d = (mask_d != 8'd0) ? ST_HOLD : ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase

        tdata_d = pick_byte(data_d, mask_d);
        tlast_d = (mask_d != 8'd0) &&
                  ((cnt_d == LAST_IDX) || (hlast_d && single_bit(mask_d)));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            data_q  <= 64'd0;
            mask_q  <= 8'd0;
            hlast_q <= 1'b0;
            cnt_q   <= 16'd0;
            frame_q <= 16'd0;
            err_q   <= 1'b0;
            tdata_q <= 8'd0;
            tlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            hlast_q <= hlast_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            err_q   <= err_d;
            tdata_q <= tdata_d;
            tlast_q <= tlast_d;
        end
    end

    assign s_axis_tready = tready_s;
    assign m_axis_tvalid = (state_q == ST_HOLD);
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign frame_count   = frame_q;
    assign null_beat_err = err_q;

endmodule

// File: tb/tb_mm2s_byte_serializer.sv
// Directed and randomized bench for mm2s_byte_serializer with a queue-based byte/frame model.
module tb_mm2s_byte_serializer;

    localparam int FB = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [15:0] frame_count;
    logic        null_beat_err;

    mm2s_byte_serializer #(.FRAME_BYTES(FB)) dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .frame_count(frame_count), .null_beat_err(null_beat_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       tl;
        logic [7:0] b;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic        rand_mode;
    logic [15:0] pos_m;
    logic [15:0] frames_m;
    logic        err_m;
    logic        stall_q;
    logic [7:0]  stall_b;
    logic        stall_l;
    logic        acc_seen;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected bytes are queued in emit order when a beat is accepted.
    task automatic model_push();
        exp_t e;
        logic lastb;
        if (s_axis_tkeep == 8'd0) begin
            err_m = 1'b1;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (s_axis_tkeep[i]) begin
                    lastb = ((s_axis_tkeep >> (i + 1)) == 8'd0);
                    e.tl  = (int'(pos_m) == FB - 1) || (s_axis_tlast && lastb);
                    e.b   = s_axis_tdata[8*i +: 8];
                    q.push_back(e);
                    pos_m = e.tl ? 16'd0 : pos_m + 16'd1;
                end
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        acc_seen = s_axis_tvalid && s_axis_tready;
        if (reset) begin
            q.delete();
            pos_m    = 16'd0;
            frames_m = 16'd0;
            err_m    = 1'b0;
            stall_q  = 1'b0;
        end else begin
            chk("frame_count", 64'(frame_count), 64'(frames_m));
            chk("null_err", 64'(null_beat_err), 64'(err_m));
            if (stall_q) begin
                chk("stall_valid", 64'(m_axis_tvalid), 64'(1'b1));
                chk("stall_data", 64'(m_axis_tdata), 64'(stall_b));
                chk("stall_last", 64'(m_axis_tlast), 64'(stall_l));
            end
            if (m_axis_tvalid) begin
                chk("valid_has_expected", 64'(q.size() != 0), 64'(1'b1));
            end
            if (m_axis_tvalid && m_axis_tready && q.size() != 0) begin
                e = q.pop_front();
                chk("out_data", 64'(m_axis_tdata), 64'(e.b));
                chk("out_last", 64'(m_axis_tlast), 64'(e.tl));
                if (e.tl) frames_m = frames_m + 16'd1;
            end
            stall_q = m_axis_tvalid && !m_axis_tready;
            stall_b = m_axis_tdata;
            stall_l = m_axis_tlast;
            if (acc_seen) model_push();
        end
    endtask

    // One clock: observe at the falling edge, then re-drive inputs just after the rising edge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (rand_mode) m_axis_tready = ($urandom_range(0, 99) < 30);
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, output int n);
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!acc_seen && n < 500);
        chk("beat_accepted", 64'(acc_seen), 64'(1'b1));
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || m_axis_tvalid) && n < 3000) begin
            step();
            n++;
        end
        chk("drain_done", 64'(q.size() == 0 && !m_axis_tvalid), 64'(1'b1));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'(1'b0));
        chk("rst_sready", 64'(s_axis_tready), 64'(1'b0));
        chk("rst_tlast", 64'(m_axis_tlast), 64'(1'b0));
        chk("rst_tdata", 64'(m_axis_tdata), 64'(8'h00));
        chk("rst_frames", 64'(frame_count), 64'(16'd0));
        chk("rst_err", 64'(null_beat_err), 64'(1'b0));
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int         n;
        logic [63:0] d;
        logic [7:0]  exp32 [4];
        reset         = 1'b1;
        rand_mode     = 1'b0;
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 64'd0;
        s_axis_tkeep  = 8'd0;
        s_axis_tlast  = 1'b0;
        pos_m = 16'd0; frames_m = 16'd0; err_m = 1'b0; stall_q = 1'b0;
        stall_b = 8'd0; stall_l = 1'b0; acc_seen = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Full beat with tlast: eight consecutive bytes starting the cycle after accept.
        send_beat(64'h0807060504030201, 8'hFF, 1'b1, n);
        for (int k = 0; k < 8; k++) begin
            chk("t030_valid", 64'(m_axis_tvalid), 64'(1'b1));
            chk("t030_data", 64'(m_axis_tdata), 64'(k + 1));
            chk("t030_last", 64'(m_axis_tlast), 64'(k == 7));
            step();
        end
        drain();
        chk("t030_frames", 64'(frame_count), 64'(16'd1));

        // Byte-count limit closes the frame mid-beat; counter restarts.
        do_reset();
        send_beat(64'h0807060504030201, 8'hFF, 1'b0, n);
        send_beat(64'h100F0E0D0C0B0A09, 8'hFF, 1'b0, n);
        drain();
        chk("t031_frames", 64'(frame_count), 64'(16'd1));

        // Sparse keep pattern, with refill ready on the final byte.
        exp32 = '{8'h22, 8'h44, 8'h55, 8'h77};
        send_beat(64'h8877665544332211, 8'h5A, 1'b0, n);
        for (int k = 0; k < 4; k++) begin
            chk("t032_valid", 64'(m_axis_tvalid), 64'(1'b1));
            chk("t032_data", 64'(m_axis_tdata), 64'(exp32[k]));
            chk("t032_sready", 64'(s_axis_tready), 64'(k == 3));
            step();
        end
        drain();

        // Empty beat: accepted at once, no output, sticky error, frame stays open.
        send_beat(64'hDEADBEEFDEADBEEF, 8'h00, 1'b1, n);
        chk("t034_one_cycle", 64'(n), 64'(1));
        chk("t034_no_valid", 64'(m_axis_tvalid), 64'(1'b0));
        chk("t034_err", 64'(null_beat_err), 64'(1'b1));
        chk("t034_frames", 64'(frame_count), 64'(16'd1));
        send_beat(64'h00000000000000AB, 8'h01, 1'b0, n);
        chk("t034_next_data", 64'(m_axis_tdata), 64'(8'hAB));
        chk("t034_next_last", 64'(m_axis_tlast), 64'(1'b0));
        drain();

        // Throttled output with counter data, then random data and keep patterns.
        rand_mode = 1'b1;
        for (int b = 0; b < 64; b++) begin
            for (int i = 0; i < 8; i++) d[8*i +: 8] = 8'((b * 8 + i) & 255);
            send_beat(d, 8'hFF, 1'($urandom_range(0, 7) == 0), n);
            if ($urandom_range(0, 3) == 0) step();
        end
        for (int b = 0; b < 32; b++) begin
            d = {$urandom, $urandom};
            send_beat(d, 8'($urandom_range(1, 255)), 1'($urandom_range(0, 3) == 0), n);
        end
        drain();
        rand_mode     = 1'b0;
        m_axis_tready = 1'b1;
        chk("err_sticky", 64'(null_beat_err), 64'(1'b1));

        // Reset after three of eight bytes: the rest must vanish.
        step();
        send_beat(64'h0807060504030201, 8'hFF, 1'b1, n);
        step();
        step();
        step();
        chk("t035_fourth", 64'(m_axis_tdata), 64'(8'h04));
        reset = 1'b1;
        step();
        chk("t035_rst_valid", 64'(m_axis_tvalid), 64'(1'b0));
        chk("t035_rst_frames", 64'(frame_count), 64'(16'd0));
        step();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t035_no_leftover", 64'(m_axis_tvalid), 64'(1'b0));
        end
        chk("t035_frames", 64'(frame_count), 64'(16'd0));
        send_beat(64'h1817161514131211, 8'hFF, 1'b0, n);
        chk("t035_restart", 64'(m_axis_tdata), 64'(8'h11));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
